// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// The optional overflow output is enabled by SERIAL_ADDER_OVERFLOW_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Combinational one-bit full adder built from two half-adder stages and an OR.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    // First half adder combines the operand bits, second folds in the carry.
    assign ha0_sum   = a ^ b;
    assign ha0_carry = a & b;
    assign sum       = ha0_sum ^ cin;
    assign ha1_carry = ha0_sum & cin;
    assign carry     = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, through a single full-adder cell.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] s_sh_reg;
    logic [WIDTH-1:0] s_sh_next;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    full_adder u_cell (
        .a     (a_sh_reg[0]),
        .b     (b_sh_reg[0]),
        .cin   (carry_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign s_sh_next = {fa_sum, s_sh_reg[WIDTH-1:1]};
    assign last_bit  = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operands load on accept, shift during SHIFT, results commit on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_sh_reg  <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    s_sh_reg  <= s_sh_next;
                    carry_reg <= fa_carry;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        sum_reg  <= s_sh_next;
                        cout_reg <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf_reg;

    // On the last bit carry_reg is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == SHIFT && last_bit) begin
            ovf_reg <= carry_reg ^ fa_carry;
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
